// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store sequencer between issue and the data-cache port
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [1:0]       req_size,
  input  logic             req_sext,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_mbe,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_resp,
  input  logic [31:0]      dmem_rdata,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [TAG_W-1:0] cpl_tag,
  output logic [31:0]      cpl_data,
  output logic             cpl_store
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic             cpl_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic             capture;
  logic             take_resp;
  logic             misalign;
  logic             store_r;
  logic [1:0]       size_r;
  logic             sext_r;
  logic [1:0]       addr_lo_r;
  logic [TAG_W-1:0] tag_r;
  logic [3:0]       mbe_calc;
  logic [31:0]      wdata_calc;
  logic [31:0]      load_data;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                    (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign cpl_tag   = tag_r;
  assign cpl_store = store_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    cpl_valid  = 1'b0;
    capture    = 1'b0;
    take_resp  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          capture    = 1'b1;
          next_state = misalign ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        dmem_read  = !store_r;
        dmem_write = store_r;
        if (dmem_resp) begin
          if (flush) begin
            next_state = IDLE;
          end else begin
            next_state = DONE;
            take_resp  = 1'b1;
          end
        end else if (flush) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        // The cache cannot abort, so the request stays up until it answers.
        dmem_read  = !store_r;
        dmem_write = store_r;
        if (dmem_resp) next_state = IDLE;
      end
      DONE: begin
        cpl_valid = 1'b1;
        if (flush || cpl_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mbe_calc   = 4'b1111;
    wdata_calc = req_wdata;
    case (req_size)
      2'b00: begin
        mbe_calc   = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mbe_calc   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        mbe_calc   = 4'b1111;
        wdata_calc = req_wdata;
      end
    endcase
  end

  always_comb begin
    load_byte = dmem_rdata[7:0];
    case (addr_lo_r)
      2'd0: load_byte = dmem_rdata[7:0];
      2'd1: load_byte = dmem_rdata[15:8];
      2'd2: load_byte = dmem_rdata[23:16];
      2'd3: load_byte = dmem_rdata[31:24];
      default: load_byte = dmem_rdata[7:0];
    endcase
    load_half = addr_lo_r[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (size_r)
      2'b00:   load_data = {{24{sext_r & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{sext_r & load_half[15]}}, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_r    <= 1'b0;
      size_r     <= 2'b00;
      sext_r     <= 1'b0;
      addr_lo_r  <= 2'b00;
      tag_r      <= '0;
      dmem_addr  <= 32'h0;
      dmem_mbe   <= 4'h0;
      dmem_wdata <= 32'h0;
      cpl_data   <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      cpl_misalign <= 1'b0;
`endif
    end else begin
      if (capture) begin
        store_r    <= req_store;
        size_r     <= req_size;
        sext_r     <= req_sext;
        addr_lo_r  <= req_addr[1:0];
        tag_r      <= req_tag;
        dmem_addr  <= {req_addr[31:2], 2'b00};
        dmem_mbe   <= mbe_calc;
        dmem_wdata <= wdata_calc;
        cpl_data   <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        cpl_misalign <= misalign;
`endif
      end
      if (take_resp) cpl_data <= store_r ? 32'h0 : load_data;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl against a transaction-level model
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_tag = 4'h0;
  logic        flush = 1'b0;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic        dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        cpl_valid;
  logic        cpl_ready = 1'b0;
  logic [3:0]  cpl_tag;
  logic [31:0] cpl_data;
  logic        cpl_store;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        cpl_misalign;
`endif

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag), .flush(flush),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_tag(cpl_tag), .cpl_data(cpl_data), .cpl_store(cpl_store)
`ifdef LSU_MISALIGN_TRAP_EN
    , .cpl_misalign(cpl_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one uop is either waiting on the cache, waiting
  // on writeback, or absent.
  bit        m_req = 0, m_drain = 0, m_cpl = 0, m_mis = 0;
  bit        m_store = 0, m_sext = 0;
  bit [1:0]  m_size = 0;
  bit [31:0] m_addr = 0, m_wdata = 0, m_data = 0;
  bit [3:0]  m_tag = 0;

  function automatic bit [3:0] exp_mbe(bit [1:0] sz, bit [31:0] a);
    int lane = int'(a % 4);
    if (sz == 0) return 4'(1 << lane);
    if (sz == 1) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic bit [31:0] exp_wdata(bit [1:0] sz, bit [31:0] d);
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit [31:0] exp_load(bit [1:0] sz, bit sx, bit [31:0] a, bit [31:0] r);
    bit [31:0] v;
    int lane = int'(a % 4);
    if (sz == 0) begin
      v = (r >> (8 * lane)) & 32'hFF;
      if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (r >> (16 * (lane / 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req = 0; m_drain = 0; m_cpl = 0; m_mis = 0;
    end else if (!m_req && !m_cpl) begin
      if (req_valid && !flush) begin
        m_store = req_store; m_size = req_size; m_sext = req_sext;
        m_addr = req_addr; m_wdata = req_wdata; m_tag = req_tag;
        m_data = 0; m_mis = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr % 4 != 0)) begin
          m_mis = 1; m_cpl = 1;
        end else
`endif
        begin
          m_req = 1; m_drain = 0;
        end
      end
    end else if (m_req) begin
      if (dmem_resp) begin
        m_req = 0;
        if (!m_drain && !flush) begin
          m_cpl = 1;
          m_data = m_store ? 32'h0 : exp_load(m_size, m_sext, m_addr, dmem_rdata);
        end
      end else if (flush) begin
        m_drain = 1;
      end
    end else if (flush || cpl_ready) begin
      m_cpl = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(!m_req && !m_cpl));
      chk("dmem_read", 32'(dmem_read), 32'(m_req && !m_store));
      chk("dmem_write", 32'(dmem_write), 32'(m_req && m_store));
      chk("cpl_valid", 32'(cpl_valid), 32'(m_cpl));
      if (m_req) begin
        chk("dmem_addr", dmem_addr, m_addr & 32'hFFFF_FFFC);
        chk("dmem_mbe", 32'(dmem_mbe), 32'(exp_mbe(m_size, m_addr)));
        chk("dmem_wdata", dmem_wdata, exp_wdata(m_size, m_wdata));
      end
      if (m_cpl) begin
        chk("cpl_tag", 32'(cpl_tag), 32'(m_tag));
        chk("cpl_data", cpl_data, m_data);
        chk("cpl_store", 32'(cpl_store), 32'(m_store));
`ifdef LSU_MISALIGN_TRAP_EN
        chk("cpl_misalign", 32'(cpl_misalign), 32'(m_mis));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit st, input bit [1:0] sz, input bit sx,
                       input bit [31:0] a, input bit [31:0] d, input bit [3:0] t);
    req_valid = 1; req_store = st; req_size = sz; req_sext = sx;
    req_addr = a; req_wdata = d; req_tag = t;
    step();
    req_valid = 0;
  endtask

  task automatic respond(input int delay, input bit [31:0] r);
    repeat (delay) step();
    dmem_resp = 1; dmem_rdata = r;
    step();
    dmem_resp = 0;
  endtask

  task automatic retire();
    cpl_ready = 1;
    step();
    cpl_ready = 0;
  endtask

  initial begin
    step();
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_dmem_read", 32'(dmem_read), 32'h0);
    chk("reset_cpl_valid", 32'(cpl_valid), 32'h0);
    chk("reset_dmem_addr", dmem_addr, 32'h0);
    step();
    rst = 0;
    step();

    // lb / lbu from the top lane
    issue(0, 2'b00, 1, 32'h1003, 32'h0, 4'h1);
    chk("lb_mbe", 32'(dmem_mbe), 32'h8);
    chk("lb_addr", dmem_addr, 32'h1000);
    respond(0, 32'h80FF_1234);
    chk("lb_data", cpl_data, 32'hFFFF_FF80);
    retire();
    issue(0, 2'b00, 0, 32'h1003, 32'h0, 4'h2);
    respond(1, 32'h80FF_1234);
    chk("lbu_data", cpl_data, 32'h0000_0080);
    retire();

    // sh to upper half
    issue(1, 2'b01, 0, 32'h2002, 32'hABCD_5678, 4'h3);
    chk("sh_write", 32'(dmem_write), 32'h1);
    chk("sh_mbe", 32'(dmem_mbe), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h5678_5678);
    respond(0, 32'hFFFF_FFFF);
    chk("sh_cpl_store", 32'(cpl_store), 32'h1);
    chk("sh_cpl_data", cpl_data, 32'h0);
    retire();

    // sb lane replication
    issue(1, 2'b00, 0, 32'h7001, 32'h0000_00A5, 4'h4);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    respond(0, 32'h0);
    retire();

    // lw with slow cache
    issue(0, 2'b10, 0, 32'h3000, 32'h0, 4'hA);
    respond(5, 32'hDEAD_BEEF);
    chk("lw_cpl_valid", 32'(cpl_valid), 32'h1);
    chk("lw_tag", 32'(cpl_tag), 32'hA);
    chk("lw_data", cpl_data, 32'hDEAD_BEEF);
    retire();

    // lh held in DONE, then flushed
    issue(0, 2'b01, 1, 32'h4002, 32'h0, 4'h5);
    respond(0, 32'h8001_0000);
    chk("lh_data", cpl_data, 32'hFFFF_8001);
    repeat (3) step();
    chk("done_hold_ready", 32'(req_ready), 32'h0);
    flush = 1;
    step();
    flush = 0;
    chk("done_flush_cpl", 32'(cpl_valid), 32'h0);
    chk("done_flush_ready", 32'(req_ready), 32'h1);

    // flush mid-ACCESS, drain until the cache answers
    issue(0, 2'b10, 0, 32'h5000, 32'h0, 4'h6);
    step();
    flush = 1;
    step();
    chk("drain_read", 32'(dmem_read), 32'h1);
    step();
    flush = 0;
    respond(2, 32'h1234_5678);
    chk("drain_ready", 32'(req_ready), 32'h1);
    chk("drain_no_cpl", 32'(cpl_valid), 32'h0);

    // flush coincident with response
    issue(0, 2'b10, 0, 32'h5004, 32'h0, 4'h7);
    flush = 1; dmem_resp = 1; dmem_rdata = 32'h5555_AAAA;
    step();
    flush = 0; dmem_resp = 0;
    chk("flush_resp_ready", 32'(req_ready), 32'h1);
    chk("flush_resp_cpl", 32'(cpl_valid), 32'h0);

    // request with flush in IDLE is ignored
    req_valid = 1; flush = 1; req_addr = 32'h6000;
    step();
    req_valid = 0; flush = 0;
    chk("idle_flush_read", 32'(dmem_read), 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 32'h3001, 32'h0, 4'h9);
    chk("mis_read", 32'(dmem_read), 32'h0);
    chk("mis_cpl_valid", 32'(cpl_valid), 32'h1);
    chk("mis_flag", 32'(cpl_misalign), 32'h1);
    chk("mis_data", cpl_data, 32'h0);
    retire();
`else
    issue(1, 2'b11, 0, 32'h6001, 32'h1122_3344, 4'h8);
    chk("sw11_mbe", 32'(dmem_mbe), 32'hF);
    chk("sw11_wdata", dmem_wdata, 32'h1122_3344);
    respond(0, 32'h0);
    retire();
    issue(0, 2'b01, 0, 32'h6001, 32'h0, 4'hB);
    chk("lh_odd_mbe", 32'(dmem_mbe), 32'h3);
    respond(0, 32'hCAFE_F00D);
    chk("lh_odd_data", cpl_data, 32'h0000_F00D);
    retire();
`endif

    // asynchronous reset mid-ACCESS
    issue(0, 2'b10, 0, 32'h9000, 32'h0, 4'hC);
    #2 rst = 1;
    #1;
    chk("arst_read", 32'(dmem_read), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h1);
    chk("arst_addr", dmem_addr, 32'h0);
    chk("arst_mbe", 32'(dmem_mbe), 32'h0);
    step();
    rst = 0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
